// File: rtl/pkg_display.sv
// Shared encodings and helpers for the multiplexed BCD display feeder.
// Used by the double-dabble converter and the scan/refresh top level.
package pkg_display;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CONV      = 2'd1,
      ACTUALIZA = 2'd2
   } estado_t;

   localparam logic [3:0]  CODIGO_BLANCO = 4'hF;
   localparam logic [13:0] VALOR_MAX     = 14'd9999;
   localparam logic [3:0]  ANODO_RESET   = 4'b1110;
   localparam int          ITERACIONES   = 14;
   localparam logic [3:0]  ULTIMA_ITER   = 4'(ITERACIONES - 1);

   // Digit i, or blank when it and every more-significant digit is zero.
   function automatic logic [3:0] digito_visible(
      input logic [15:0] d,
      input logic [1:0]  i
   );
      logic [15:0] alto;
      alto = d >> {i, 2'b00};
      if ((i != 2'd0) && (alto == 16'h0000))
         return CODIGO_BLANCO;
      return alto[3:0];
   endfunction

   function automatic logic [3:0] anodo_de(input logic [1:0] i);
      return ~(4'b0001 << i);
   endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Sequential shift-add-3 converter: 14-bit binary to four BCD digits,
// one iteration per clock, result valid while listo is high.
module bin_a_bcd
   import pkg_display::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        inicio,
   input  logic [13:0] binario,
   output logic [15:0] bcd,
   output logic        listo,
   output logic        ocupado
);

   estado_t     estado_q, estado_d;
   logic [13:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  iter_q, iter_d;
   logic [15:0] ajustado;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         iter_q   <= '0;
      end else begin
         estado_q <= estado_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         iter_q   <= iter_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      iter_d   = iter_q;
      ajustado = bcd_q;
      for (int k = 0; k < 4; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5)
            ajustado[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
      unique case (estado_q)
         IDLE: begin
            if (inicio) begin
               bin_d    = binario;
               bcd_d    = '0;
               iter_d   = '0;
               estado_d = CONV;
            end
         end
         CONV: begin
            {bcd_d, bin_d} = {ajustado, bin_q} << 1;
            iter_d         = iter_q + 4'd1;
            if (iter_q == ULTIMA_ITER)
               estado_d = ACTUALIZA;
         end
         ACTUALIZA: begin
            estado_d = IDLE;
         end
         default: begin
            estado_d = IDLE;
         end
      endcase
   end

   assign bcd     = bcd_q;
   assign listo   = (estado_q == ACTUALIZA);
   assign ocupado = (estado_q != IDLE);

endmodule

// File: rtl/barrido_display.sv
// Saturates and converts a binary value, then scans the four BCD digits
// onto a shared digit bus with active-low anodes and leading-zero blanking.
module barrido_display
   import pkg_display::*;
#(
   parameter int DIV_REFRESCO = 50000,
   parameter int ANCHO        = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ANCHO-1:0] valor,
   input  logic             cargar,
   output logic             ocupado,
   output logic [3:0]       numeroen,
   output logic [3:0]       anodo
);

   localparam int          CW      = $clog2(DIV_REFRESCO);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV_REFRESCO - 1);

   logic [13:0]   saturado;
   logic [15:0]   bcd;
   logic          listo;

   logic [15:0]   digitos_q, digitos_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    numeroen_q, numeroen_d;
   logic [3:0]    anodo_q, anodo_d;

   always_comb begin
      saturado = valor[13:0];
      if (32'(valor) > 32'(VALOR_MAX))
         saturado = VALOR_MAX;
   end

   bin_a_bcd u_conv (
      .clk     (clk),
      .reset   (reset),
      .inicio  (cargar),
      .binario (saturado),
      .bcd     (bcd),
      .listo   (listo),
      .ocupado (ocupado)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digitos_q  <= 16'h0000;
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         numeroen_q <= 4'h0;
         anodo_q    <= ANODO_RESET;
      end else begin
         digitos_q  <= digitos_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         numeroen_q <= numeroen_d;
         anodo_q    <= anodo_d;
      end
   end

   // A wrap coinciding with listo still shows the old digits.
   always_comb begin
      digitos_d  = digitos_q;
      cnt_d      = cnt_q + 1'b1;
      idx_d      = idx_q;
      numeroen_d = numeroen_q;
      anodo_d    = anodo_q;
      if (listo)
         digitos_d = bcd;
      if (cnt_q == CNT_MAX) begin
         cnt_d      = '0;
         idx_d      = idx_q + 2'd1;
         numeroen_d = digito_visible(digitos_q, idx_d);
         anodo_d    = anodo_de(idx_d);
      end
   end

   assign numeroen = numeroen_q;
   assign anodo    = anodo_q;

endmodule

// File: tb/tb_barrido_display.sv
// Bench for barrido_display: directed and random loads checked against
// a decimal-arithmetic model of what each scan slot should show.
module tb_barrido_display;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] valor;
   logic        cargar;
   logic        ocupado;
   logic [3:0]  numeroen;
   logic [3:0]  anodo;

   int          chk = 0;
   int          err = 0;
   logic [3:0]  obs [4];
   int          anodo_malo;

   barrido_display #(
      .DIV_REFRESCO (DIV),
      .ANCHO        (14)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .valor    (valor),
      .cargar   (cargar),
      .ocupado  (ocupado),
      .numeroen (numeroen),
      .anodo    (anodo)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] modelo(input int v, input int i);
      int x;
      int p;
      x = (v > 9999) ? 9999 : v;
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      if (i > 0 && x < p) return 4'hF;
      return 4'((x / p) % 10);
   endfunction

   // Pulse cargar for one edge and count busy cycles (bounded).
   task automatic cargar_valor(input int v, output int n);
      @(negedge clk);
      valor  = 14'(v);
      cargar = 1'b1;
      @(posedge clk);
      #1 cargar = 1'b0;
      n = 0;
      @(negedge clk);
      while (ocupado && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Let the display settle, then record one full scan per anode.
   task automatic capturar();
      anodo_malo = 0;
      for (int i = 0; i < 4; i++) obs[i] = 4'hx;
      repeat (5*DIV + 2) @(negedge clk);
      for (int k = 0; k < 4*DIV; k++) begin
         @(negedge clk);
         case (anodo)
            4'b1110: obs[0] = numeroen;
            4'b1101: obs[1] = numeroen;
            4'b1011: obs[2] = numeroen;
            4'b0111: obs[3] = numeroen;
            default: anodo_malo++;
         endcase
      end
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      cargar = 1'b0;
      valor  = '0;
      #1 reset = 1'b1;
      #2;
      chk++;
      if (anodo !== 4'b1110 || numeroen !== 4'h0 || ocupado !== 1'b0) begin
         err++;
         $display("FAIL reset_outputs got an=%b num=%h oc=%b want 1110/0/0",
                  anodo, numeroen, ocupado);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      capturar();
      for (int i = 0; i < 4; i++) begin
         chk++;
         if (obs[i] !== modelo(0, i)) begin
            err++;
            $display("FAIL reset_slot%0d got %h want %h", i, obs[i], modelo(0, i));
         end
      end
   endtask

   task automatic test_load(input int v, input string nombre);
      int n;
      cargar_valor(v, n);
      chk++;
      if (n != 15) begin
         err++;
         $display("FAIL %s_busy got %0d cycles want 15", nombre, n);
      end
      capturar();
      chk++;
      if (anodo_malo != 0) begin
         err++;
         $display("FAIL %s_anodo got %0d bad samples want 0", nombre, anodo_malo);
      end
      for (int i = 0; i < 4; i++) begin
         chk++;
         if (obs[i] !== modelo(v, i)) begin
            err++;
            $display("FAIL %s_slot%0d got %h want %h", nombre, i, obs[i], modelo(v, i));
         end
      end
   endtask

   task automatic test_dwell();
      logic [3:0] cur;
      logic [3:0] esperado;
      int n;
      @(negedge clk);
      cur = anodo;
      n = 0;
      while (anodo === cur && n < 4*DIV) begin
         @(negedge clk);
         n++;
      end
      for (int r = 0; r < 4; r++) begin
         cur = anodo;
         esperado = {cur[2:0], cur[3]};
         n = 1;
         @(negedge clk);
         while (anodo === cur && n < 50) begin
            n++;
            @(negedge clk);
         end
         chk++;
         if (n != DIV || anodo !== esperado) begin
            err++;
            $display("FAIL dwell%0d got %0d cycles next=%b want %0d next=%b",
                     r, n, anodo, DIV, esperado);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk++;
      if (anodo !== 4'b1110 || numeroen !== 4'h0 || ocupado !== 1'b0) begin
         err++;
         $display("FAIL midscan_reset got an=%b num=%h oc=%b want 1110/0/0",
                  anodo, numeroen, ocupado);
      end
      @(negedge clk);
      reset = 1'b0;
      capturar();
      for (int i = 0; i < 4; i++) begin
         chk++;
         if (obs[i] !== modelo(0, i)) begin
            err++;
            $display("FAIL midscan_slot%0d got %h want %h", i, obs[i], modelo(0, i));
         end
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      @(negedge clk);
      valor  = 14'd42;
      cargar = 1'b1;
      @(posedge clk);
      #1 cargar = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ocupado) n++;
         if (k == 2) begin
            valor  = 14'd88;
            cargar = 1'b1;
         end else begin
            cargar = 1'b0;
         end
      end
      chk++;
      if (n != 15) begin
         err++;
         $display("FAIL busy_ignore_busy got %0d cycles want 15", n);
      end
      capturar();
      for (int i = 0; i < 4; i++) begin
         chk++;
         if (obs[i] !== modelo(42, i)) begin
            err++;
            $display("FAIL busy_ignore_slot%0d got %h want %h", i, obs[i], modelo(42, i));
         end
      end
   endtask

   task automatic test_reset_conv();
      @(negedge clk);
      valor  = 14'd5678;
      cargar = 1'b1;
      @(posedge clk);
      #1 cargar = 1'b0;
      repeat (6) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk++;
      if (ocupado !== 1'b0) begin
         err++;
         $display("FAIL conv_reset_busy got %b want 0", ocupado);
      end
      @(negedge clk);
      reset = 1'b0;
      capturar();
      for (int i = 0; i < 4; i++) begin
         chk++;
         if (obs[i] !== modelo(0, i)) begin
            err++;
            $display("FAIL conv_reset_slot%0d got %h want %h", i, obs[i], modelo(0, i));
         end
      end
      test_load(5678, "reload5678");
   endtask

   task automatic test_random();
      int v;
      for (int r = 0; r < 8; r++) begin
         v = int'($urandom_range(0, 16383));
         if (r == 0) v = int'($urandom_range(0, 99));
         test_load(v, $sformatf("rand%0d_v%0d", r, v));
      end
   endtask

   initial begin
      test_reset();
      test_load(1234, "load1234");
      test_dwell();
      test_reset_mid_scan();
      test_load(7, "load7");
      test_load(105, "load105");
      test_load(16383, "sat16383");
      test_load(9999, "load9999");
      test_load(0, "load0");
      test_busy_ignore();
      test_reset_conv();
      test_random();
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
